instruction_sequencer: RTL and testbench

//  Program-counter and fetch controller for the MiniALU core. Drives the combinational instruction ROM address,

---
 rtl/instruction_sequencer_pkg.sv | 17 +
 rtl/instruction_sequencer_if.sv | 21 ++
 rtl/instruction_sequencer_seq_delay_counter.sv | 24 ++
 rtl/instruction_sequencer.sv | 76 +++++++
 tb/tb_instruction_sequencer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/instruction_sequencer_pkg.sv
// instruction_sequencer_pkg: shared widths, opcode encodings, field positions and FSM states for the sequencer.
package instruction_sequencer_pkg;
    localparam int ADDR_W   = 16;
    localparam int INSTR_W  = 28;
    localparam int TARGET_W = 8;
    localparam int DELAY_W  = 24;
    localparam int OPC_MSB  = INSTR_W - 1;
    localparam int OPC_LSB  = INSTR_W - 4;
    localparam int IMM_MSB  = INSTR_W - 5;
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_SMUL = 4'h3;
    localparam logic [3:0] OPC_BLE  = 4'h4;
    localparam logic [3:0] OPC_JMP  = 4'h5;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DELAY = 2'd2} state_e;
endpackage

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: ROM fetch, issue and execute-feedback signals of the sequencer.
interface instruction_sequencer_if;
    import instruction_sequencer_pkg::*;
    logic                enable;
    logic [ADDR_W-1:0]   rom_address;
    logic [INSTR_W-1:0]  rom_instruction;
    logic [INSTR_W-1:0]  instruction;
    logic                instr_valid;
    logic                stall;
    logic                branch_taken;
    logic [TARGET_W-1:0] branch_target;
    logic                delay_active;
    modport master (
        input  enable, rom_instruction, stall, branch_taken, branch_target,
        output rom_address, instruction, instr_valid, delay_active
    );
    modport slave (
        output enable, rom_instruction, stall, branch_taken, branch_target,
        input  rom_address, instruction, instr_valid, delay_active
    );
endinterface

// File: rtl/instruction_sequencer_seq_delay_counter.sv
// seq_delay_counter: NOP wait counter with load/decrement and last/zero flags; exists only with SEQ_NOP_DELAY_EN.
`ifdef SEQ_NOP_DELAY_EN
module seq_delay_counter
    import instruction_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic               dec,
    input  logic [DELAY_W-1:0] load_val,
    output logic               last,
    output logic               zero
);
    logic [DELAY_W-1:0] count_q, count_d;
    always_comb count_d = clr ? '0 : load ? load_val : (dec && !zero) ? count_q - DELAY_W'(1) : count_q;
    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
    assign zero = count_q == '0;
    assign last = count_q == DELAY_W'(1);
endmodule
`endif

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: PC/fetch controller with stall, branch redirect and, under SEQ_NOP_DELAY_EN,
// NOP-immediate counted waits.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    instruction_sequencer_if.master bus
);
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               adv, redirect, fetch, delay_nop, delay_done;
    assign adv      = !bus.stall;
    assign redirect = adv && bus.branch_taken;
    assign fetch    = adv && !bus.branch_taken && state_q != DELAY && bus.enable;
`ifdef SEQ_NOP_DELAY_EN
    logic cnt_last, cnt_zero;
    assign delay_nop = bus.rom_instruction[OPC_MSB:OPC_LSB] == OPC_NOP && bus.rom_instruction[IMM_MSB:0] != '0;
    seq_delay_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (redirect),
        .load     (fetch && delay_nop),
        .dec      (adv && state_q == DELAY),
        .load_val (bus.rom_instruction[IMM_MSB:0]),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );
    assign delay_done       = cnt_last || cnt_zero;
    assign bus.delay_active = state_q == DELAY;
`else
    assign delay_nop        = 1'b0;
    assign delay_done       = 1'b1;
    assign bus.delay_active = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (redirect) begin
            pc_d    = {{(ADDR_W-TARGET_W){1'b0}}, bus.branch_target};
            valid_d = 1'b0;
            state_d = RUN;
        end else if (adv && state_q == DELAY) begin
            valid_d = 1'b0;
            state_d = delay_done ? (bus.enable ? RUN : IDLE) : DELAY;
        end else if (fetch) begin
            instr_d = bus.rom_instruction;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = delay_nop ? DELAY : RUN;
        end else if (adv) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end
    assign bus.rom_address = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: table-driven fetch/stall/branch vectors plus hand sequences for delay, reset and PC wrap.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;
`ifdef SEQ_NOP_DELAY_EN
    localparam logic DLY = 1'b1;
`else
    localparam logic DLY = 1'b0;
`endif
    typedef struct packed {
        logic        en, st, br;
        logic [7:0]  tgt;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] iaddr;
        logic        dly;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];
    instruction_sequencer_if bus ();
    instruction_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [27:0] rom(input logic [15:0] a);
        if (a == 16'd0)  return {OPC_NOP, 24'd4};
        if (a == 16'd11) return {OPC_BLE, 24'h00000A};
        return {OPC_ADD, 8'h00, a};
    endfunction
    assign bus.rom_instruction = rom(bus.rom_address);
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step(input logic en, input logic st, input logic br, input logic [7:0] tgt);
        bus.enable = en;
        bus.stall = st;
        bus.branch_taken = br;
        bus.branch_target = tgt;
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string tag, input logic [15:0] addr, input logic valid,
                              input logic [15:0] iaddr, input logic dly);
        check({tag, " addr"}, 32'(bus.rom_address), 32'(addr));
        check({tag, " valid"}, 32'(bus.instr_valid), 32'(valid));
        if (valid) check({tag, " instr"}, 32'(bus.instruction), 32'(rom(iaddr)));
        check({tag, " delay"}, 32'(bus.delay_active), 32'(dly));
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst_n = 1'b1;
    endtask
    task automatic expect_reset(input string tag);
        check({tag, " addr"}, 32'(bus.rom_address), 32'd0);
        check({tag, " valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, " instr"}, 32'(bus.instruction), 32'd0);
        check({tag, " delay"}, 32'(bus.delay_active), 32'd0);
    endtask
    task automatic add(input logic en, input logic st, input logic br, input logic [7:0] tgt,
                       input logic [15:0] addr, input logic valid, input logic [15:0] iaddr, input logic dly);
        vecs.push_back('{en, st, br, tgt, addr, valid, iaddr, dly});
    endtask
    initial begin
        int cyc;
        bus.enable = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 8'd0;
        // PC0 holds NOP #4: a counted wait with the macro, a plain instruction without it
`ifdef SEQ_NOP_DELAY_EN
        add(1, 0, 0, 0, 1, 1, 0, 1);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 0);
`else
        add(1, 0, 0, 0, 1, 1, 0, 0);
`endif
        for (int p = 1; p < 5; p++) add(1, 0, 0, 0, 16'(p + 1), 1, 16'(p), 0);
        for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 5, 1, 4, 0);
        for (int p = 5; p < 12; p++) add(1, 0, 0, 0, 16'(p + 1), 1, 16'(p), 0);
        add(1, 0, 1, 10, 10, 0, 0, 0);
        add(1, 0, 0, 0, 11, 1, 10, 0);
        add(0, 0, 0, 0, 11, 0, 0, 0);
        add(0, 0, 0, 0, 11, 0, 0, 0);
        add(1, 0, 0, 0, 12, 1, 11, 0);
        add(1, 1, 1, 3, 12, 1, 11, 0);
        add(1, 0, 1, 3, 3, 0, 0, 0);
        add(1, 0, 0, 0, 4, 1, 3, 0);
        do_reset();
        expect_reset("reset");
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].st, vecs[i].br, vecs[i].tgt);
            expect_out($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].iaddr, vecs[i].dly);
        end
        rst_n = 1'b0;
        step(1, 1, 0, 0);
        rst_n = 1'b1;
        expect_reset("reset_in_stall");
`ifdef SEQ_NOP_DELAY_EN
        do_reset();
        step(1, 0, 0, 0);
        expect_out("dly_rst nop", 1, 1, 0, 1);
        step(1, 0, 0, 0);
        expect_out("dly_rst wait", 1, 0, 0, 1);
        rst_n = 1'b0;
        step(1, 0, 0, 0);
        rst_n = 1'b1;
        expect_reset("reset_in_delay");
        do_reset();
        step(1, 0, 0, 0);
        expect_out("dly_drop nop", 1, 1, 0, 1);
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 0, 0);
            expect_out($sformatf("dly_drop stall%0d", k), 1, 1, 0, 1);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            expect_out($sformatf("dly_drop cnt%0d", k), 1, 0, 0, 1);
        end
        step(0, 0, 0, 0);
        expect_out("dly_drop exit", 1, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_out("dly_drop idle", 1, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("dly_drop resume", 2, 1, 1, 0);
        do_reset();
        step(1, 0, 0, 0);
        expect_out("dly_br nop", 1, 1, 0, 1);
        step(1, 0, 1, 7);
        expect_out("dly_br redirect", 7, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("dly_br issue", 8, 1, 7, 0);
`endif
        do_reset();
        bus.enable = 1'b1;
        cyc = 0;
        while (bus.rom_address != 16'hFFFF && cyc < 70000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wrap reach", 32'(bus.rom_address), 32'hFFFF);
        step(1, 0, 0, 0);
        expect_out("wrap", 16'h0000, 1, 16'hFFFF, 0);
        step(1, 0, 0, 0);
        expect_out("wrap next", 16'h0001, 1, 16'h0000, DLY);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
